// File: rtl/scene_uart_tx.sv
// UART 8N1 transmitter for one scene-parameter frame: a sync byte followed by
// NUM_BYTES payload bytes fetched through rd_idx/rd_data, LSB first.
module scene_uart_tx #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          NUM_BYTES    = 55,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [5:0] rd_idx,
  input  logic [7:0] rd_data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int            TW        = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);
  localparam logic [5:0]    LAST_BYTE = 6'(NUM_BYTES);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, NEXT} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [5:0]    byte_cnt_q, byte_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          bit_end;

  assign bit_end = (timer_q == TIMER_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (start) begin
          shift_d    = SYNC_BYTE;
          byte_cnt_d = '0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_end) begin
          timer_d   = '0;
          bit_cnt_d = '0;
          state_d   = DATA;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          timer_d = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          timer_d = '0;
          state_d = NEXT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      NEXT: begin
        timer_d = '0;
        // Counter is cleared on the way back to IDLE so rd_idx idles at 0.
        if (byte_cnt_q == LAST_BYTE) begin
          byte_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          shift_d    = rd_data;
          byte_cnt_d = byte_cnt_q + 6'd1;
          state_d    = START;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state values so they line up with the state.
  always_comb begin
    done_d = (state_d == NEXT) && (byte_cnt_d == LAST_BYTE);
    busy_d = (state_d != IDLE) && !done_d;
    tx_d   = 1'b1;
    if (state_d == START) begin
      tx_d = 1'b0;
    end else if (state_d == DATA) begin
      tx_d = shift_d[0];
    end
  end

  assign rd_idx = byte_cnt_q;
  assign tx     = tx_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_scene_uart_tx.sv
// Directed bench for scene_uart_tx: two instances (short 4-byte frame with sync A5,
// full 55-byte frame with sync 01), cycle-accurate tx capture and decode.
module tb_scene_uart_tx;

  logic       clk;
  logic       reset;
  logic       start_a, start_b;
  logic [5:0] rd_idx_a, rd_idx_b;
  logic [7:0] rd_data_a, rd_data_b;
  logic       tx_a, tx_b, busy_a, busy_b, done_a, done_b;

  int total;
  int bad;
  int done_cnt;

  logic cap_tx   [0:2400];
  logic cap_busy [0:2400];
  logic cap_done [0:2400];

  scene_uart_tx #(.CLKS_PER_BIT(4), .NUM_BYTES(4), .SYNC_BYTE(8'hA5)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .rd_idx(rd_idx_a),
    .rd_data(rd_data_a), .tx(tx_a), .busy(busy_a), .done(done_a)
  );

  scene_uart_tx #(.CLKS_PER_BIT(4), .NUM_BYTES(55), .SYNC_BYTE(8'h01)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .rd_idx(rd_idx_b),
    .rd_data(rd_data_b), .tx(tx_b), .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Parameter register mux model: word p = {8'h80+p, 8'h40+p}, slot 50 unused.
  function automatic logic [7:0] srcByte(input logic [5:0] idx);
    if (idx == 6'd50) return 8'h00;
    if (idx[0]) return 8'h80 + {3'b000, idx[5:1]};
    return 8'h40 + {3'b000, idx[5:1]};
  endfunction

  assign rd_data_a = 8'h10 + {2'b00, rd_idx_a};
  assign rd_data_b = srcByte(rd_idx_b);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pulses start on the selected instance, then records ncyc cycles starting
  // with the first start-bit cycle; extra start pulses go in after cycles p1/p2.
  task automatic applyStimulus(input bit sel, input int ncyc, input int p1, input int p2);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    if (sel) start_b = 1'b0; else start_a = 1'b0;
    done_cnt = 0;
    for (int k = 1; k <= ncyc; k++) begin
      cap_tx[k]   = sel ? tx_b   : tx_a;
      cap_busy[k] = sel ? busy_b : busy_a;
      cap_done[k] = sel ? done_b : done_a;
      if (cap_done[k]) done_cnt++;
      if (sel) start_b = (k == p1) || (k == p2);
      else     start_a = (k == p1) || (k == p2);
      @(negedge clk);
    end
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic checkByte(input string tag, input int b, input logic [7:0] exp);
    int base;
    logic [7:0] v;
    base = b * 41 + 1;
    for (int i = 0; i < 8; i++) v[i] = cap_tx[base + 4 + 4 * i + 1];
    checkOutput($sformatf("%s_start%0d", tag, b), {31'd0, cap_tx[base + 1]}, 32'd0);
    checkOutput($sformatf("%s_byte%0d", tag, b), {24'd0, v}, {24'd0, exp});
    checkOutput($sformatf("%s_stop%0d", tag, b), {31'd0, cap_tx[base + 37]}, 32'd1);
  endtask

  task automatic checkIdle(input string tag, input bit sel, input int n);
    for (int k = 0; k < n; k++) begin
      if (sel) checkOutput(tag, {23'd0, tx_b, busy_b, done_b, rd_idx_b}, {23'd0, 3'b100, 6'd0});
      else     checkOutput(tag, {23'd0, tx_a, busy_a, done_a, rd_idx_a}, {23'd0, 3'b100, 6'd0});
      @(negedge clk);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    done_cnt = 0;
    reset    = 1'b1;
    start_a  = 1'b0;
    start_b  = 1'b0;

    @(negedge clk);
    checkOutput("reset_a", {23'd0, tx_a, busy_a, done_a, rd_idx_a}, {23'd0, 3'b100, 6'd0});
    checkOutput("reset_b", {23'd0, tx_b, busy_b, done_b, rd_idx_b}, {23'd0, 3'b100, 6'd0});
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 100; k++) begin
      checkOutput("idle_a", {23'd0, tx_a, busy_a, done_a, rd_idx_a}, {23'd0, 3'b100, 6'd0});
      checkOutput("idle_b", {23'd0, tx_b, busy_b, done_b, rd_idx_b}, {23'd0, 3'b100, 6'd0});
      @(negedge clk);
    end

    $display("[TB] short frame with start pulses mid-frame and in done cycle");
    applyStimulus(1'b0, 205, 60, 205);
    checkOutput("frame_busy_first", {31'd0, cap_busy[1]}, 32'd1);
    checkOutput("frame_busy_before_done", {31'd0, cap_busy[204]}, 32'd1);
    checkOutput("frame_done_at_205", {31'd0, cap_done[205]}, 32'd1);
    checkOutput("frame_busy_at_done", {31'd0, cap_busy[205]}, 32'd0);
    checkOutput("frame_done_count", done_cnt, 32'd1);
    checkByte("frame", 0, 8'hA5);
    checkByte("frame", 1, 8'h10);
    checkByte("frame", 2, 8'h11);
    checkByte("frame", 3, 8'h12);
    checkByte("frame", 4, 8'h13);
    checkIdle("after_frame_a", 1'b0, 30);

    $display("[TB] bit timing and full 55-byte frame");
    applyStimulus(1'b1, 2296, -1, -1);
    for (int k = 1; k <= 41; k++) begin
      logic e;
      e = (k <= 4) ? 1'b0 : (k <= 8) ? 1'b1 : (k <= 36) ? 1'b0 : 1'b1;
      checkOutput($sformatf("bit_timing_c%0d", k), {31'd0, cap_tx[k]}, {31'd0, e});
    end
    checkByte("full", 0, 8'h01);
    for (int k = 0; k < 55; k++) checkByte("full", k + 1, srcByte(6'(k)));
    checkOutput("full_done_at_end", {31'd0, cap_done[2296]}, 32'd1);
    checkOutput("full_busy_at_done", {31'd0, cap_busy[2296]}, 32'd0);
    checkOutput("full_done_count", done_cnt, 32'd1);
    checkIdle("after_frame_b", 1'b1, 10);

    $display("[TB] reset during data of payload byte 2");
    applyStimulus(1'b0, 140, -1, -1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset_state", {23'd0, tx_a, busy_a, done_a, rd_idx_a}, {23'd0, 3'b100, 6'd0});
    reset = 1'b0;
    checkIdle("midreset_idle", 1'b0, 5);
    applyStimulus(1'b0, 205, -1, -1);
    checkByte("rerun", 0, 8'hA5);
    checkByte("rerun", 1, 8'h10);
    checkByte("rerun", 4, 8'h13);
    checkOutput("rerun_done_at_205", {31'd0, cap_done[205]}, 32'd1);
    checkOutput("rerun_done_count", done_cnt, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
